// File: rtl/conv_pkg.sv
// Shared constants, state encoding and parity helper for the rate-1/2 K=7
// convolutional frame encoder.
package conv_pkg;

    localparam int CONV_K = 7;
    localparam int SR_W   = CONV_K - 1;
    localparam int CNT_W  = 16;

    localparam logic [CONV_K-1:0] CONV_G0 = 7'o133;
    localparam logic [CONV_K-1:0] CONV_G1 = 7'o171;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        TAIL
    } conv_state_e;

    function automatic logic parity(input logic [CONV_K-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/conv_frame_encoder_if.sv
// Bit-in / symbol-out handshake bundle of the convolutional frame encoder.
// The master modport is the encoder side.
interface conv_frame_encoder_if;

    logic       din;
    logic       din_valid;
    logic       din_ready;
    logic [1:0] code_out;
    logic       code_valid;
    logic       code_ready;
    logic       sof;
    logic       eof;

    modport master (
        input  din, din_valid, code_ready,
        output din_ready, code_out, code_valid, sof, eof
    );

    modport slave (
        output din, din_valid, code_ready,
        input  din_ready, code_out, code_valid, sof, eof
    );

endinterface

// File: rtl/conv_encode_core.sv
// Six-bit encoder memory plus the two generator parity trees.
// The code symbol is combinational in the current input bit; the caller registers it.
module conv_encode_core
    import conv_pkg::*;
#(
    parameter logic [CONV_K-1:0] G0 = CONV_G0,
    parameter logic [CONV_K-1:0] G1 = CONV_G1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       en,
    input  logic       din,
    output logic [1:0] code
);

    // sr_q[SR_W-1] is the most recent bit, so {din, sr_q} lines up with the
    // generator bit order (bit 6 = current input, bit 0 = oldest bit).
    logic [SR_W-1:0]   sr_q;
    logic [SR_W-1:0]   sr_d;
    logic [CONV_K-1:0] u;

    always_comb begin
        u    = {din, sr_q};
        code = {parity(u & G1), parity(u & G0)};
        sr_d = sr_q;
        if (clear) begin
            sr_d = '0;
        end else if (en) begin
            sr_d = {din, sr_q[SR_W-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

endmodule

// File: rtl/conv_frame_encoder.sv
// Frame-level K=7 rate-1/2 convolutional encoder: FRAME_LEN data bits followed by
// six zero tail bits, one-entry output register with valid/ready backpressure.
module conv_frame_encoder
    import conv_pkg::*;
#(
    parameter int unsigned       FRAME_LEN = 64,
    parameter logic [CONV_K-1:0] G0        = CONV_G0,
    parameter logic [CONV_K-1:0] G1        = CONV_G1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    conv_frame_encoder_if.master bus
);

    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] LAST_TAIL = CNT_W'(SR_W - 1);

    conv_state_e      state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [1:0]       code_q, code_d;
    logic             valid_q, valid_d;
    logic             sof_q, sof_d;
    logic             eof_q, eof_d;

    logic       free;
    logic       accept;
    logic       tail_step;
    logic       enc_en;
    logic       enc_clear;
    logic       enc_din;
    logic [1:0] enc_code;

    conv_encode_core #(
        .G0 (G0),
        .G1 (G1)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .clear (enc_clear),
        .en    (enc_en),
        .din   (enc_din),
        .code  (enc_code)
    );

    always_comb begin
        free      = !valid_q || bus.code_ready;
        accept    = (state_q == DATA) && free && bus.din_valid;
        tail_step = (state_q == TAIL) && free;
        enc_en    = accept || tail_step;
        enc_din   = accept && bus.din;
        // A start that lands while the final eof symbol is still pending is dropped.
        enc_clear = (state_q == IDLE) && start && !valid_q;

        state_d = state_q;
        count_d = count_q;
        code_d  = code_q;
        valid_d = valid_q;
        sof_d   = sof_q;
        eof_d   = eof_q;

        if (valid_q && bus.code_ready) begin
            valid_d = 1'b0;
            sof_d   = 1'b0;
            eof_d   = 1'b0;
        end
        if (enc_en) begin
            code_d  = enc_code;
            valid_d = 1'b1;
            sof_d   = accept && (count_q == '0);
            eof_d   = tail_step && (count_q == LAST_TAIL);
        end

        case (state_q)
            IDLE: begin
                if (enc_clear) begin
                    state_d = DATA;
                    count_d = '0;
                end
            end
            DATA: begin
                if (accept) begin
                    if (count_q == LAST_DATA) begin
                        state_d = TAIL;
                        count_d = '0;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            TAIL: begin
                if (tail_step) begin
                    if (count_q == LAST_TAIL) begin
                        state_d = IDLE;
                        count_d = '0;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            eof_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            sof_q   <= sof_d;
            eof_q   <= eof_d;
        end
    end

    assign bus.din_ready  = (state_q == DATA) && free;
    assign bus.code_out   = code_q;
    assign bus.code_valid = valid_q;
    assign bus.sof        = sof_q;
    assign bus.eof        = eof_q;
    assign busy           = (state_q != IDLE) || valid_q;

endmodule

// File: tb/tb_conv_frame_encoder.sv
// Randomized bench for conv_frame_encoder: three instances (FRAME_LEN 1/64/255),
// symbols checked against a direct convolution reference model.
module tb_conv_frame_encoder;

    localparam int         FL [3] = '{1, 64, 255};
    localparam logic [6:0] GEN0   = 7'o133;
    localparam logic [6:0] GEN1   = 7'o171;

    logic clk        = 1'b0;
    logic rst        = 1'b1;
    logic start      = 1'b0;
    logic din        = 1'b0;
    logic din_valid  = 1'b0;
    logic code_ready = 1'b0;
    int   sel        = 0;

    logic [1:0] co_a   [3];
    logic       cv_a   [3];
    logic       sof_a  [3];
    logic       eof_a  [3];
    logic       dr_a   [3];
    logic       busy_a [3];

    logic [1:0] code_out;
    logic       code_valid, sof, eof, din_ready, busy;

    int         chk_cnt  = 0;
    int         pass_cnt = 0;
    bit         bits_q [$];
    logic [1:0] got_q  [$];
    logic [7:0] lfsr;
    logic [1:0] imp_exp [7] = '{2'b11, 2'b10, 2'b11, 2'b11, 2'b00, 2'b01, 2'b11};

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        conv_frame_encoder_if bus ();

        assign bus.din        = din;
        assign bus.din_valid  = din_valid;
        assign bus.code_ready = code_ready;

        conv_frame_encoder #(.FRAME_LEN(FL[gi])) u_dut (
            .clk   (clk),
            .rst   (rst),
            .start (start && (sel == gi)),
            .busy  (busy_a[gi]),
            .bus   (bus)
        );

        assign co_a[gi]  = bus.code_out;
        assign cv_a[gi]  = bus.code_valid;
        assign sof_a[gi] = bus.sof;
        assign eof_a[gi] = bus.eof;
        assign dr_a[gi]  = bus.din_ready;
    end

    always_comb begin
        code_out   = co_a[sel];
        code_valid = cv_a[sel];
        sof        = sof_a[sel];
        eof        = eof_a[sel];
        din_ready  = dr_a[sel];
        busy       = busy_a[sel];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Symbol j of the frame = mod-2 convolution of the bit sequence (zero beyond
    // the frame, which provides the tail) with the generator taps.
    function automatic logic [1:0] ref_sym(input int j);
        int c0 = 0;
        int c1 = 0;
        for (int k = 0; k < 7; k++) begin
            int t = j - k;
            int x = (t >= 0 && t < bits_q.size()) ? int'(bits_q[t]) : 0;
            c0 += x * int'(GEN0[6-k]);
            c1 += x * int'(GEN1[6-k]);
        end
        return {1'(c1 % 2), 1'(c0 % 2)};
    endfunction

    // Runs one frame on instance idx with the bits in bits_q; called at a negedge.
    task automatic run_frame(input int idx, input int ready_pct, input bit abuse, input int abort_at);
        int         n = bits_q.size();
        int         nxt = 0;
        int         cyc = 0;
        int         j;
        bit         done = 0;
        bit         prev_in = 0;
        bit         prev_stall = 0;
        bit         in_f, out_f;
        logic [1:0] prev_code = 2'b00;
        logic       prev_sof = 1'b0;
        logic       prev_eof = 1'b0;
        got_q.delete();
        sel   = idx;
        start = 1'b1;
        @(negedge clk);
        while (!done && cyc < 5000) begin
            if (prev_in) check_eq("latency", 32'(code_valid), 32'd1);
            if (prev_stall) begin
                check_eq("hold_code", 32'(code_out), 32'(prev_code));
                check_eq("hold_flags", 32'({code_valid, sof, eof}), 32'({1'b1, prev_sof, prev_eof}));
            end
            code_ready = ($urandom_range(99) < ready_pct);
            din_valid  = abuse || (ready_pct == 100) || ($urandom_range(9) < 8);
            din        = (nxt < n) ? bits_q[nxt] : 1'($urandom);
            start      = abuse && busy && ($urandom_range(3) == 0);
            #1;
            in_f  = din_valid && din_ready;
            out_f = code_valid && code_ready;
            if (out_f) begin
                j = got_q.size();
                $display("frame_len=%0d sym %0d code=%b sof=%b eof=%b", FL[idx], j, code_out, sof, eof);
                check_eq("symbol", 32'(code_out), 32'(ref_sym(j)));
                check_eq("sof", 32'(sof), 32'(j == 0));
                check_eq("eof", 32'(eof), 32'(j == n + 5));
                got_q.push_back(code_out);
                done = (j == n + 5);
            end
            if (in_f) nxt++;
            prev_in    = in_f;
            prev_stall = code_valid && !code_ready;
            prev_code  = code_out;
            prev_sof   = sof;
            prev_eof   = eof;
            @(posedge clk);
            if (abort_at > 0 && got_q.size() == abort_at) begin
                @(negedge clk);
                rst        = 1'b1;
                start      = 1'b0;
                din_valid  = 1'b0;
                code_ready = 1'b0;
                @(posedge clk);
                #1;
                check_eq("rst_outputs", 32'({code_out, code_valid, sof, eof, din_ready, busy}), 32'd0);
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            @(negedge clk);
            cyc++;
        end
        if (!done) check_eq("timeout", 32'd0, 32'd1);
        check_eq("bits_used", 32'(nxt), 32'(n));
        check_eq("busy_after", 32'(busy), 32'd0);
        start     = 1'b0;
        din_valid = abuse;
        for (int c = 0; c < 8; c++) begin
            code_ready = 1'($urandom);
            #1;
            check_eq("idle_quiet", 32'({code_valid, din_ready, busy}), 32'd0);
            @(negedge clk);
        end
        din_valid = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            sel = i;
            #1;
            check_eq("reset_state", 32'({code_out, code_valid, sof, eof, din_ready, busy}), 32'd0);
        end
        @(negedge clk);

        // Impulse response on FRAME_LEN=1
        bits_q.delete();
        bits_q.push_back(1'b1);
        run_frame(0, 100, 1'b0, 0);
        check_eq("impulse_len", 32'(got_q.size()), 32'd7);
        for (int i = 0; i < 7 && i < got_q.size(); i++) check_eq("impulse", 32'(got_q[i]), 32'(imp_exp[i]));

        // All-zero frame
        bits_q.delete();
        repeat (64) bits_q.push_back(1'b0);
        run_frame(1, 100, 1'b0, 0);
        check_eq("zero_len", 32'(got_q.size()), 32'd70);

        // Random data, full rate then 50% backpressure
        bits_q.delete();
        repeat (64) bits_q.push_back(1'($urandom));
        run_frame(1, 100, 1'b0, 0);
        run_frame(1, 50, 1'b0, 0);
        check_eq("bp_len", 32'(got_q.size()), 32'd70);

        // m-sequence feed, x^8+x^6+x^5+x^4+1 seeded with all ones
        bits_q.delete();
        lfsr = 8'hFF;
        for (int i = 0; i < 255; i++) begin
            bits_q.push_back(lfsr[7]);
            lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
        run_frame(2, 70, 1'b0, 0);
        check_eq("mseq_len", 32'(got_q.size()), 32'd261);
        check_eq("final_state", 32'(g_dut[2].u_dut.u_core.sr_q), 32'd0);

        // Control abuse: stray start pulses, din_valid held high
        bits_q.delete();
        repeat (64) bits_q.push_back(1'($urandom));
        run_frame(1, 60, 1'b1, 0);

        // Reset mid-frame, then a clean all-zero frame
        bits_q.delete();
        repeat (64) bits_q.push_back(1'b0);
        run_frame(1, 100, 1'b0, 30);
        run_frame(1, 100, 1'b0, 0);
        check_eq("after_rst_len", 32'(got_q.size()), 32'd70);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/conv_frame_encoder.md
Name: conv_frame_encoder

Overview:
- Rate-1/2, constraint-length-7 convolutional encoder placed directly downstream of the m-sequence generator.
- Consumes one information bit per handshake (m-sequence or other test data) and emits 2-bit code symbols.
- Works on fixed-length frames and appends K-1 zero tail bits so the trellis terminates in state 0.
- Drives the channel/modulator stage through a valid/ready interface and supports backpressure.

Parameters:
- FRAME_LEN, 64, information bits per frame (1..65535).
- G0, 7'o133, generator polynomial for code_out[0]; bit 6 taps the current input, bit 0 taps the oldest stored bit.
- G1, 7'o171, generator polynomial for code_out[1]; same bit mapping as G0.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  single-cycle pulse that begins a frame; honoured only in IDLE.
- din  in  1  information bit.
- din_valid  in  1  din is valid.
- din_ready  out  1  encoder accepts din this cycle.
- code_out  out  2  code symbol {c1,c0}.
- code_valid  out  1  code_out is valid.
- code_ready  in  1  downstream accepts code_out.
- sof  out  1  qualifies the first symbol of a frame; valid only with code_valid.
- eof  out  1  qualifies the last tail symbol of a frame; valid only with code_valid.
- busy  out  1  high in DATA or TAIL, or while a symbol is still pending.

Behaviour:
- Clocking: one clock domain, clk. Synchronous active-high reset rst is fixed.
- Reset values: all outputs 0; state IDLE; 6-bit encoder shift register 0; bit counter 0; output register empty.
  - Reset mid-frame aborts the frame. The pending symbol is dropped with no eof.
- Output-free condition: free = !code_valid || code_ready (one-entry output register).
- States:
  - IDLE: din_ready=0. On start: clear shift register and counter, go to DATA.
  - DATA: din_ready=free. On din_valid && din_ready:
    - u = {din, sr[0..5]}, where sr[0] is the most recent bit.
    - c0 = XOR-reduce(u & G0); c1 = XOR-reduce(u & G1).
    - Register code_out = {c1,c0}, code_valid=1, sof=(count==0).
    - Shift din into sr[0]; increment count.
    - On the FRAME_LEN-th accepted bit, go to TAIL with count=0.
  - TAIL: din_ready=0. Each cycle that free=1, encode an internal 0 the same way.
    - After 6 tail symbols, set eof on the 6th and go to IDLE.
- Latency: exactly 1 cycle from an accepted bit (or tail step) to code_valid.
- Backpressure: while code_valid && !code_ready, code_out, sof and eof hold stable and no new bit is accepted. Same-cycle drain and refill is allowed (full throughput, 1 symbol/clk).
- Frame length: a frame is always FRAME_LEN + 6 symbols.
- FRAME_LEN=1: the only symbol carries sof; eof comes 6 symbols later. sof and eof never coincide.
- start outside IDLE is ignored and has no side effect.
- start in the same cycle as the last eof handshake is ignored. The next start must arrive in IDLE.
- din_valid in IDLE or TAIL is not consumed (din_ready=0).
- busy deasserts the cycle after the eof symbol is accepted.

Decomposition:
- Shared package conv_pkg holds:
  - constants CONV_K=7, CONV_G0=7'o133, CONV_G1=7'o171;
  - state enum {IDLE, DATA, TAIL};
  - parity function.
- One natural sub-module, conv_encode_core: 6-bit shift register plus the two parity trees, with an enable/clear interface. The top level owns the FSM, counters and output register.

Test Plan:
- Impulse: FRAME_LEN=1, din=1, code_ready=1 -> symbols 11,10,11,11,00,01,11; sof on the 1st, eof on the 7th.
- All-zero frame: FRAME_LEN=64, din=0 -> 70 symbols, all 2'b00; sof on the 1st, eof on the 70th; busy low afterwards.
- Backpressure: random code_ready at 50% -> symbol stream identical to the code_ready=1 run. code_out is stable whenever valid && !ready. No bit is lost or duplicated.
- m-sequence feed:
  - Setup: FRAME_LEN=255, driven by an x^8 LFSR source loaded with 0xFF.
  - Expected: 261 symbols match the reference model, and the final encoder state is 0.
- Control abuse: start pulsed during DATA and TAIL, and din_valid held high in IDLE/TAIL -> no extra frames, no consumed bits, counts unchanged.
- Reset mid-frame: assert rst at the 30th symbol -> next cycle all outputs 0, state IDLE. A fresh start then reproduces the all-zero frame result exactly.
